// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, writeback select, pipeline control types.
package cpu_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  // Memory-side FSM; it only feeds the watchdog, never the stage controls.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

  // Canned control words for each pipeline action.
  localparam stage_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam stage_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam stage_ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam stage_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
module hazard_detect (
  input  logic       i_ex_is_load,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  output logic       o_load_use
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  // x0 never carries a real dependency, so loads targeting it never stall.
  always_comb begin
    w_hit_rs1  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    w_hit_rs2  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    o_load_use = i_ex_is_load && (i_ex_rd != 5'd0) && (w_hit_rs1 || w_hit_rs2);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline control: freeze/branch/load-use arbitration, memory
// watchdog and saturating stall/flush performance counters.
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_freeze;
  logic              w_load_use;
  logic              w_stall_evt;
  logic              w_flush_evt;
  stage_ctrl_t       w_ctrl;

  hazard_detect u_hazard (
    .i_ex_is_load (ex_is_load),
    .i_ex_rd      (ex_rd),
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_use_rs1 (id_use_rs1),
    .i_id_use_rs2 (id_use_rs2),
    .o_load_use   (w_load_use)
  );

  assign w_freeze = mem_req && !mem_ready;

  // Stage controls: reset > freeze > branch > load-use > run. A branch seen
  // during freeze simply waits in EX and wins on the first unfrozen cycle.
  always_comb begin
    w_ctrl      = CTRL_RUN;
    w_stall_evt = 1'b0;
    w_flush_evt = 1'b0;
    if (rst) begin
      w_ctrl = CTRL_RUN;
    end else if (w_freeze) begin
      w_ctrl      = CTRL_FREEZE;
      w_stall_evt = 1'b1;
    end else if (ex_branch_taken) begin
      w_ctrl      = CTRL_BRANCH;
      w_flush_evt = 1'b1;
    end else if (w_load_use) begin
      w_ctrl      = CTRL_LOAD_USE;
      w_stall_evt = 1'b1;
    end
  end

  assign pc_en       = w_ctrl.pc_en;
  assign if_id_en    = w_ctrl.if_id_en;
  assign id_ex_en    = w_ctrl.id_ex_en;
  assign ex_mem_en   = w_ctrl.ex_mem_en;
  assign mem_wb_en   = w_ctrl.mem_wb_en;
  assign if_id_flush = w_ctrl.if_id_flush;
  assign id_ex_flush = w_ctrl.id_ex_flush;

  // Next state and watchdog count. The count includes the cycle in which the
  // wait is first seen, so it equals the number of consecutive frozen cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:      if (w_freeze) w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ready || !mem_req) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
    if (w_state_nxt == RUN) w_wait_nxt = '0;
    else if (r_wait_cnt != '1) w_wait_nxt = r_wait_cnt + 1'b1;
    else w_wait_nxt = r_wait_cnt;
  end

  // State register, watchdog and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_state_nxt == MEM_WAIT && w_wait_nxt >= WAIT_LIMIT) r_timeout <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign mem_timeout = r_timeout;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of consecutive MEM_WAIT cycles after which mem_timeout SHALL set.
REQ-002 Parameter CNT_W, default 32, is the width of the stall and flush performance counters.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_is_load  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  MEM stage is issuing a data-SRAM access.
- mem_ready  in  1  data SRAM has completed the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage-register load enables.
- if_id_flush, id_ex_flush  out  1 each  insert a bubble (NOP, reg_write_en=0) into that register.
- mem_timeout  out  1  sticky watchdog flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-004 freeze SHALL be mem_req && !mem_ready; while freeze is high, all five enables SHALL be 0 and both flushes SHALL be 0, in any state.
REQ-005 When freeze is low and ex_branch_taken is high, all enables SHALL be 1 and if_id_flush = id_ex_flush = 1.
REQ-006 Load-use SHALL be: ex_is_load && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)).
REQ-007 When freeze and ex_branch_taken are both low and load-use is high, the outputs SHALL be: pc_en = 0, if_id_en = 0, id_ex_flush = 1, and ex_mem_en = mem_wb_en = id_ex_en = 1.
REQ-008 Priority SHALL be freeze > branch > load-use.
- With branch and load-use together, the branch action applies; the dependent ID instruction is flushed.
- A branch that arrives during freeze is held in EX and applied on the first non-freeze cycle.
REQ-009 When no condition is active, all enables SHALL be 1 and all flushes 0.
REQ-010 The FSM SHALL have two states, RUN and MEM_WAIT.
- RUN -> MEM_WAIT when freeze is high.
- MEM_WAIT -> RUN when mem_ready is high, or when mem_req drops.
- Outputs are combinational from the inputs per REQ-004 to REQ-009; the state only drives the watchdog.
REQ-011 wait_cnt SHALL be 8 bits or wider.
- Cleared on entry to RUN; incremented each cycle in MEM_WAIT.
- When it reaches TIMEOUT_CYCLES, mem_timeout SHALL set and stay set until rst.
- wait_cnt SHALL saturate and never wrap.
REQ-012 stall_cnt SHALL increment on each cycle with freeze or load-use stall active.
REQ-013 flush_cnt SHALL increment on each cycle in which a branch flush is applied.
REQ-014 Both counters SHALL saturate at all-ones.
REQ-015 A single cycle with mem_req && mem_ready in RUN SHALL cause no stall and no state change.

Reset
REQ-016 While rst is high:
- all enables = 1, flushes = 0; pipeline registers reset themselves.
- state = RUN; wait_cnt = 0, mem_timeout = 0, stall_cnt = 0, flush_cnt = 0.
REQ-017 Asserting rst during MEM_WAIT SHALL return the block to RUN on the next edge, with no residual freeze unless mem_req && !mem_ready is still present.

Structure
REQ-018 The state enum (RUN, MEM_WAIT) and the stage-control struct type (five enables, two flushes) SHALL live in the shared CPU package, alongside the existing opcode and wb_sel definitions.
REQ-019 One sub-module, hazard_detect, SHALL hold the purely combinational load-use compare; the FSM, watchdog and counters SHALL stay in pipeline_ctrl.

Verification
REQ-020 The bench SHALL cover at least these scenarios:
- Load-use: ex_is_load = 1, ex_rd = 5, id_rs1 = 5, id_use_rs1 = 1 -> pc_en = 0, if_id_en = 0, id_ex_flush = 1 for exactly one cycle; stall_cnt = 1.
- x0 load: ex_is_load = 1, ex_rd = 0, id_rs1 = 0 -> no stall, all enables 1.
- Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles, then ready -> all enables 0 for 3 cycles; state MEM_WAIT, then RUN; stall_cnt = 3.
- Branch under freeze: ex_branch_taken = 1 while frozen 2 cycles -> no flush while frozen; both flushes 1 on the release cycle; flush_cnt = 1.
- Timeout: TIMEOUT_CYCLES = 4, mem_ready held 0 -> mem_timeout = 1 after the 4th wait cycle; stays 1 after mem_ready; clears only on rst.
- Reset mid-wait: rst pulsed in MEM_WAIT with mem_req = 0 -> next cycle state RUN, all counters 0, all enables 1.
